// File: rtl/skew_shift_bank.sv
// skew_shift_bank: bank of word shift registers with load/upload/write/read and a skewed stream.
// Define SKEW_SHIFT_BANK_SKEW_EN to delay channel c by c steps during STREAM.
module skew_shift_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4,
  parameter int CHANNELS   = 4
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [2:0]                             ctrl_code,
  input  logic [CHANNELS*LENGTH*DATA_WIDTH-1:0]  data_in,
  input  logic [CHANNELS*DATA_WIDTH-1:0]         data_write,
  output logic [CHANNELS*LENGTH*DATA_WIDTH-1:0]  data_out,
  output logic                                   out_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0]         data_read,
  output logic [CHANNELS-1:0]                    read_valid,
  output logic                                   stream_last
);
`ifdef SKEW_SHIFT_BANK_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif
  localparam int T  = LENGTH + SKEW * (CHANNELS - 1);
  localparam int TW = $clog2(T + 1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t r_state, w_next;
  logic [TW-1:0] r_t, w_step;
  logic [DATA_WIDTH-1:0] r_mem [CHANNELS][LENGTH];
  logic [CHANNELS*LENGTH*DATA_WIDTH-1:0] w_flat;
  logic [CHANNELS*DATA_WIDTH-1:0] w_sdata;
  logic [CHANNELS-1:0] w_svalid;
  logic w_go, w_stream_on;
  assign cmd_ready = r_state == IDLE;
  assign w_go = cmd_valid && cmd_ready;
  // w_step is the stream step whose outputs get registered on this edge
  assign w_step = (r_state == IDLE) ? '0 : r_t + TW'(1);
  assign w_stream_on = (r_state == IDLE) ? (w_go && ctrl_code == 3'd5) : (r_t != TW'(T - 1));
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_go && ctrl_code == 3'd5) w_next = STREAM;
    if (r_state == STREAM && r_t == TW'(T - 1)) w_next = IDLE;
  end
  always_comb begin
    w_flat   = '0;
    w_sdata  = '0;
    w_svalid = '0;
    for (int c = 0; c < CHANNELS; c++)
      for (int w = 0; w < LENGTH; w++) begin
        w_flat[(c*LENGTH+w)*DATA_WIDTH +: DATA_WIDTH] = r_mem[c][w];
        if (int'(w_step) == w + SKEW * c) begin
          w_sdata[c*DATA_WIDTH +: DATA_WIDTH] = r_mem[c][w];
          w_svalid[c] = 1'b1;
        end
      end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_t         <= '0;
      data_out    <= '0;
      out_valid   <= 1'b0;
      data_read   <= '0;
      read_valid  <= '0;
      stream_last <= 1'b0;
      for (int c = 0; c < CHANNELS; c++)
        for (int w = 0; w < LENGTH; w++) r_mem[c][w] <= '0;
    end else begin
      r_state     <= w_next;
      r_t         <= (r_state == STREAM && r_t != TW'(T - 1)) ? r_t + TW'(1) : '0;
      out_valid   <= 1'b0;
      data_read   <= w_stream_on ? w_sdata : '0;
      read_valid  <= w_stream_on ? w_svalid : '0;
      stream_last <= w_stream_on && w_step == TW'(T - 1);
      if (w_go) begin
        case (ctrl_code)
          3'd1: for (int c = 0; c < CHANNELS; c++)
                  for (int w = 0; w < LENGTH; w++)
                    r_mem[c][w] <= data_in[(c*LENGTH+w)*DATA_WIDTH +: DATA_WIDTH];
          3'd2: begin
            data_out  <= w_flat;
            out_valid <= 1'b1;
          end
          3'd3, 3'd4: for (int c = 0; c < CHANNELS; c++) begin
            for (int w = 0; w < LENGTH - 1; w++) r_mem[c][w] <= r_mem[c][w+1];
            r_mem[c][LENGTH-1] <= (ctrl_code == 3'd3) ? data_write[c*DATA_WIDTH +: DATA_WIDTH] : r_mem[c][0];
          end
          3'd6: for (int c = 0; c < CHANNELS; c++)
                  for (int w = 0; w < LENGTH; w++) r_mem[c][w] <= '0;
          default: ;
        endcase
        if (ctrl_code == 3'd4) begin
          for (int c = 0; c < CHANNELS; c++) data_read[c*DATA_WIDTH +: DATA_WIDTH] <= r_mem[c][0];
          read_valid <= '1;
        end
      end
    end
  end
endmodule

// File: tb/tb_skew_shift_bank.sv
// tb_skew_shift_bank: directed bench with a contents/step model checked every cycle.
module tb_skew_shift_bank;
  localparam int DW = 8, L = 4, C = 3;
`ifdef SKEW_SHIFT_BANK_SKEW_EN
  localparam int SK = 1;
`else
  localparam int SK = 0;
`endif
  localparam int T = L + SK * (C - 1);
  logic clk = 0, reset_n = 1, cmd_valid = 0, cmd_ready, out_valid, stream_last;
  logic [2:0] ctrl_code = 0;
  logic [C*L*DW-1:0] data_in = '0, data_out;
  logic [C*DW-1:0] data_write = '0, data_read;
  logic [C-1:0] read_valid;
  skew_shift_bank #(.DATA_WIDTH(DW), .LENGTH(L), .CHANNELS(C)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .ctrl_code(ctrl_code), .data_in(data_in), .data_write(data_write), .data_out(data_out),
    .out_valid(out_valid), .data_read(data_read), .read_valid(read_valid), .stream_last(stream_last));
  always #5 clk = ~clk;
  logic [7:0] mem [C][L];
  logic [C*L*DW-1:0] e_dout;
  logic [C*DW-1:0] e_dr;
  logic [C-1:0] e_rv;
  logic e_ov, e_last;
  bit e_stream, chk;
  int s, n_vec, n_err;
  localparam logic [C*L*DW-1:0] IMG = 96'h24232221_14131211_04030201;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [C*L*DW-1:0] flat();
    logic [C*L*DW-1:0] f;
    for (int c = 0; c < C; c++) for (int w = 0; w < L; w++) f[(c*L+w)*8 +: 8] = mem[c][w];
    return f;
  endfunction
  task automatic show();
    for (int c = 0; c < C; c++) begin
      int w = s - SK * c;
      if (w >= 0 && w < L) begin
        e_rv[c] = 1'b1;
        e_dr[c*8 +: 8] = mem[c][w];
      end
    end
    e_last = (s == T - 1);
  endtask
  task automatic model_reset();
    for (int c = 0; c < C; c++) for (int w = 0; w < L; w++) mem[c][w] = 8'h00;
    e_dout = '0; e_dr = '0; e_rv = '0; e_ov = 0; e_last = 0; e_stream = 0; s = 0;
  endtask
  task automatic model_edge(input logic [2:0] code, input bit v);
    e_ov = 0; e_rv = '0; e_dr = '0; e_last = 0;
    if (e_stream) begin
      if (s == T - 1) e_stream = 0;
      else begin s++; show(); end
    end else if (v) case (code)
      3'd1: for (int c = 0; c < C; c++) for (int w = 0; w < L; w++) mem[c][w] = data_in[(c*L+w)*8 +: 8];
      3'd2: begin e_dout = flat(); e_ov = 1; end
      3'd3: for (int c = 0; c < C; c++) begin
        for (int w = 0; w < L - 1; w++) mem[c][w] = mem[c][w+1];
        mem[c][L-1] = data_write[c*8 +: 8];
      end
      3'd4: for (int c = 0; c < C; c++) begin
        logic [7:0] h = mem[c][0];
        e_dr[c*8 +: 8] = h;
        for (int w = 0; w < L - 1; w++) mem[c][w] = mem[c][w+1];
        mem[c][L-1] = h;
        e_rv[c] = 1'b1;
      end
      3'd5: begin e_stream = 1; s = 0; show(); end
      3'd6: for (int c = 0; c < C; c++) for (int w = 0; w < L; w++) mem[c][w] = 8'h00;
      default: ;
    endcase
  endtask
  task automatic tick(input logic [2:0] code, input bit v);
    ctrl_code = code; cmd_valid = v;
    @(posedge clk); #1;
    model_edge(code, v);
    cmd_valid = 0; ctrl_code = 0;
  endtask
  always @(negedge clk) if (chk) begin
    check("cmd_ready", cmd_ready, !e_stream);
    check("data_out", data_out, e_dout);
    check("out_valid", out_valid, e_ov);
    check("data_read", data_read, e_dr);
    check("read_valid", read_valid, e_rv);
    check("stream_last", stream_last, e_last);
  end
  initial begin
    model_reset();
    #1 reset_n = 0;
    chk = 1;
    #13 reset_n = 1;
    check("reset data_out", data_out, 0);
    check("reset ready", cmd_ready, 1);
    tick(0, 1);
    data_in = IMG;
    tick(1, 1);
    tick(2, 1);
    check("upload image", data_out, IMG);
    check("upload strobe", out_valid, 1);
    tick(5, 1);
    check("step0 rv", read_valid, SK ? 3'b001 : 3'b111);
    check("step0 data", data_read, SK ? 24'h000001 : 24'h211101);
    check("step0 ready", cmd_ready, 0);
    for (int k = 1; k <= T; k++) begin
      tick(6, 1);
      if (k == 2) check("step2 data", data_read, SK ? 24'h211203 : 24'h231303);
      if (k == T - 1) begin
        check("last rv", read_valid, SK ? 3'b100 : 3'b111);
        check("last data", data_read, SK ? 24'h240000 : 24'h241404);
        check("last flag", stream_last, 1);
      end
      if (k == T) check("ready after stream", cmd_ready, 1);
    end
    tick(2, 1);
    check("stream non-destructive", data_out, IMG);
    tick(4, 1);
    check("read data", data_read, 24'h211101);
    check("read rv", read_valid, 3'b111);
    tick(2, 1);
    check("read rotate ch0", data_out[31:0], 32'h01040302);
    tick(1, 1);
    data_write = 24'hCCBBAA;
    tick(3, 1);
    tick(2, 1);
    check("write image", data_out, 96'hCC242322_BB141312_AA040302);
    data_in = ~IMG;
    tick(1, 0);
    tick(7, 1);
    tick(6, 1);
    tick(0, 1);
    tick(2, 1);
    check("clear", data_out, 0);
    data_in = IMG;
    tick(1, 1);
    for (int k = 0; k < 6; k++) begin
      data_write = 24'h10203 * (k + 5);
      tick((k % 2) ? 3'd4 : 3'd3, 1);
    end
    tick(5, 1);
    for (int k = 0; k < T + 2; k++) tick(4, 1);
    tick(2, 1);
    tick(5, 1);
    tick(0, 0);
    tick(0, 0);
    reset_n = 0;
    #1;
    check("async rst rv", read_valid, 0);
    check("async rst dr", data_read, 0);
    check("async rst dout", data_out, 0);
    model_reset();
    @(negedge clk); #2 reset_n = 1;
    check("ready after rst", cmd_ready, 1);
    tick(2, 1);
    check("upload after rst", data_out, 0);
    tick(0, 1);
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
